// File: rtl/selection_history.sv
// Records selector results in arrival order, flags repeats/overflow, then
// replays the recorded sequence cyclically with a programmable dwell per entry.
module selection_history #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 3,
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic [DW-1:0] out_digit,
    output logic [DW-1:0] out_index,
    output logic          out_valid,
    output logic          replaying,
    output logic [DW:0]   count,
    output logic          dup_err,
    output logic          overflow
);

    localparam int unsigned    CW         = DW + 1;
    localparam int unsigned    DWELL_EFF  = (DWELL == 0) ? 1 : DWELL;
    localparam logic [31:0]    DWELL_LAST = 32'(DWELL_EFF - 1);
    localparam logic [CW-1:0]  FULL       = CW'(DEPTH);

    typedef enum logic {
        CAPTURE = 1'b0,
        REPLAY  = 1'b1
    } state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [DEPTH-1:0] seen;
    logic [DW-1:0] rd_ptr;
    logic [DW-1:0] wr_ptr;
    logic [DW-1:0] nxt_ptr;
    logic [31:0]   dcnt;
    logic          full;
    logic          wr_en;
    logic          start;

    assign wr_ptr  = count[DW-1:0];
    assign full    = (count == FULL);
    assign wr_en   = (state == CAPTURE) && !clear && in_valid && !full;
    assign start   = (state == CAPTURE) && !clear && in_last && ((count != '0) || in_valid);
    // Replay wraps at the last recorded slot, not at DEPTH
    assign nxt_ptr = ({1'b0, rd_ptr} == (count - CW'(1))) ? '0 : rd_ptr + DW'(1);

    // History storage; contents are never visible while count is zero
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CAPTURE;
            count     <= '0;
            seen      <= '0;
            rd_ptr    <= '0;
            dcnt      <= '0;
            dup_err   <= 1'b0;
            overflow  <= 1'b0;
            out_digit <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            replaying <= 1'b0;
        end else if (clear) begin
            state     <= CAPTURE;
            count     <= '0;
            seen      <= '0;
            rd_ptr    <= '0;
            dcnt      <= '0;
            dup_err   <= 1'b0;
            overflow  <= 1'b0;
            out_digit <= '0;
            out_index <= '0;
            out_valid <= 1'b0;
            replaying <= 1'b0;
        end else begin
            case (state)
                CAPTURE: begin
                    if (in_valid) begin
                        if (!full) begin
                            count          <= count + CW'(1);
                            seen[in_data]  <= 1'b1;
                            out_digit      <= in_data;
                            out_index      <= wr_ptr;
                            out_valid      <= 1'b1;
                            if (seen[in_data]) begin
                                dup_err <= 1'b1;
                            end
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    // A same-cycle capture into an empty history lands in slot 0
                    if (start) begin
                        state     <= REPLAY;
                        replaying <= 1'b1;
                        out_valid <= 1'b1;
                        rd_ptr    <= '0;
                        dcnt      <= '0;
                        out_index <= '0;
                        out_digit <= (count == '0) ? in_data : mem[0];
                    end
                end
                REPLAY: begin
                    if (dcnt == DWELL_LAST) begin
                        dcnt      <= '0;
                        rd_ptr    <= nxt_ptr;
                        out_digit <= mem[nxt_ptr];
                        out_index <= nxt_ptr;
                    end else begin
                        dcnt <= dcnt + 32'd1;
                    end
                end
                default: begin
                    state     <= CAPTURE;
                    replaying <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selection_history.sv
// Randomized and directed bench for selection_history with a queue-based
// reference model shared by three instances (DWELL = 3, 0, 1).
module tb_selection_history;

    localparam int DEPTH = 8;
    localparam int NI    = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic [2:0] in_data = 3'd0;

    logic [2:0] out_digit [NI];
    logic [2:0] out_index [NI];
    logic       out_valid [NI];
    logic       replaying [NI];
    logic [3:0] count     [NI];
    logic       dup_err   [NI];
    logic       overflow  [NI];

    int dwell_eff [NI] = '{3, 1, 1};

    always #5 clk = ~clk;

    selection_history #(.DEPTH(8), .DW(3), .DWELL(3)) u0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .out_digit(out_digit[0]), .out_index(out_index[0]),
        .out_valid(out_valid[0]), .replaying(replaying[0]), .count(count[0]),
        .dup_err(dup_err[0]), .overflow(overflow[0]));

    selection_history #(.DEPTH(8), .DW(3), .DWELL(0)) u1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .out_digit(out_digit[1]), .out_index(out_index[1]),
        .out_valid(out_valid[1]), .replaying(replaying[1]), .count(count[1]),
        .dup_err(dup_err[1]), .overflow(overflow[1]));

    selection_history #(.DEPTH(8), .DW(3), .DWELL(1)) u2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .out_digit(out_digit[2]), .out_index(out_index[2]),
        .out_valid(out_valid[2]), .replaying(replaying[2]), .count(count[2]),
        .dup_err(dup_err[2]), .overflow(overflow[2]));

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history as a queue, replay position from elapsed cycles
    int hist[$];
    bit m_rep;
    bit m_dup;
    bit m_ovf;
    int m_last_d;
    int m_last_i;
    int rep_t;

    task automatic model_reset();
        hist.delete();
        m_rep    = 1'b0;
        m_dup    = 1'b0;
        m_ovf    = 1'b0;
        m_last_d = 0;
        m_last_i = 0;
        rep_t    = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else if (clear) begin
            model_reset();
        end else if (!m_rep) begin
            if (in_valid) begin
                if (hist.size() < DEPTH) begin
                    foreach (hist[i]) if (hist[i] == int'(in_data)) m_dup = 1'b1;
                    m_last_i = hist.size();
                    m_last_d = int'(in_data);
                    hist.push_back(int'(in_data));
                end else begin
                    m_ovf = 1'b1;
                end
            end
            if (in_last && hist.size() != 0) begin
                m_rep = 1'b1;
                rep_t = 0;
            end
        end else begin
            rep_t++;
        end
    end

    function automatic int exp_index(input int k);
        if (m_rep) return (rep_t / dwell_eff[k]) % hist.size();
        return m_last_i;
    endfunction

    function automatic int exp_digit(input int k);
        if (m_rep) return hist[exp_index(k)];
        return m_last_d;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("u%0d out_digit", k), 32'(out_digit[k]), exp_digit(k));
                check($sformatf("u%0d out_index", k), 32'(out_index[k]), exp_index(k));
                check($sformatf("u%0d out_valid", k), 32'(out_valid[k]),
                      (m_rep || hist.size() != 0) ? 1 : 0);
                check($sformatf("u%0d replaying", k), 32'(replaying[k]), m_rep ? 1 : 0);
                check($sformatf("u%0d count", k), 32'(count[k]), hist.size());
                check($sformatf("u%0d dup_err", k), 32'(dup_err[k]), m_dup ? 1 : 0);
                check($sformatf("u%0d overflow", k), 32'(overflow[k]), m_ovf ? 1 : 0);
            end
        end
    end

    task automatic cyc(input logic iv, input logic [2:0] d, input logic il, input logic cl);
        in_valid = iv;
        in_data  = d;
        in_last  = il;
        clear    = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic il);
        repeat (n) cyc(1'b0, 3'd0, il, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " digit"}, 32'(out_digit[0]), 0);
        check({tag, " index"}, 32'(out_index[0]), 0);
        check({tag, " valid"}, 32'(out_valid[0]), 0);
        check({tag, " replaying"}, 32'(replaying[0]), 0);
        check({tag, " count"}, 32'(count[0]), 0);
        check({tag, " dup"}, 32'(dup_err[0]), 0);
        check({tag, " ovf"}, 32'(overflow[0]), 0);
    endtask

    int seqv [8] = '{5, 2, 7, 0, 1, 6, 3, 4};
    int errv [5] = '{0, 2, 3, 5, 6};

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        #9 check_zero("reset");
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sequential capture then replay
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 3'(seqv[i]), 1'b0, 1'b0);
            check("seq count", 32'(count[0]), i + 1);
            check("seq digit", 32'(out_digit[0]), seqv[i]);
        end
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        check("replay start", 32'(replaying[0]), 1);
        check("replay first digit", 32'(out_digit[0]), 5);
        check("replay first index", 32'(out_index[0]), 0);
        idle(2, 1'b1);
        check("dwell hold", 32'(out_digit[0]), 5);
        idle(1, 1'b1);
        check("dwell advance", 32'(out_digit[0]), 2);
        check("dwell1 slot3", 32'(out_digit[2]), 0);

        // Replay ignores new inputs and in_last falling
        cyc(1'b1, 3'd7, 1'b0, 1'b0);
        check("isolation count", 32'(count[0]), 8);
        check("isolation dup", 32'(dup_err[0]), 0);
        idle(10, 1'b0);

        // Clear during slot 2, then recapture
        begin
            int guard = 0;
            while (out_index[0] != 3'd2 && guard < 40) begin
                idle(1, 1'b0);
                guard++;
            end
            if (guard >= 40) begin
                n_chk++;
                n_fail++;
                $display("FAIL slot2 wait: got timeout expected index 2");
            end
        end
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        check_zero("clear");
        cyc(1'b1, 3'd3, 1'b0, 1'b0);
        check("recapture count", 32'(count[0]), 1);
        check("recapture digit", 32'(out_digit[0]), 3);

        // Simultaneous last value and in_last
        cyc(1'b1, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 3'd2, 1'b0, 1'b0);
        cyc(1'b1, 3'd6, 1'b1, 1'b0);
        check("simul count", 32'(count[0]), 4);
        check("simul replaying", 32'(replaying[0]), 1);
        check("simul first", 32'(out_digit[0]), 3);
        idle(9, 1'b1);
        check("simul slot3 digit", 32'(out_digit[0]), 6);
        check("simul slot3 index", 32'(out_index[0]), 3);
        idle(3, 1'b1);
        check("simul wrap", 32'(out_digit[0]), 3);

        // Asynchronous reset mid-replay
        idle(4, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_zero("async reset");
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Duplicate then overflow
        cyc(1'b1, 3'd1, 1'b0, 1'b0);
        cyc(1'b1, 3'd4, 1'b0, 1'b0);
        cyc(1'b1, 3'd1, 1'b0, 1'b0);
        check("dup flag", 32'(dup_err[0]), 1);
        check("dup count", 32'(count[0]), 3);
        for (int i = 0; i < 5; i++) cyc(1'b1, 3'(errv[i]), 1'b0, 1'b0);
        cyc(1'b1, 3'd2, 1'b0, 1'b0);
        check("ovf flag", 32'(overflow[0]), 1);
        check("ovf count", 32'(count[0]), 8);
        check("ovf digit", 32'(out_digit[0]), 6);
        check("ovf index", 32'(out_index[0]), 7);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        idle(30, 1'b1);

        // Single entry with short dwell
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        cyc(1'b1, 3'd5, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            for (int k = 1; k < NI; k++) begin
                check("single digit", 32'(out_digit[k]), 5);
                check("single index", 32'(out_index[k]), 0);
            end
            idle(1, 1'b1);
        end

        // in_last with an empty history stays in capture
        cyc(1'b0, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 3'd0, 1'b1, 1'b0);
            check("empty last", 32'(replaying[0]), 0);
        end

        // Randomized rounds
        repeat (25) begin
            int n;
            cyc(1'b0, 3'd0, 1'b0, 1'b1);
            n = $urandom_range(1, 10);
            for (int j = 0; j < n; j++) begin
                idle($urandom_range(0, 2), 1'b0);
                cyc(1'b1, 3'($urandom_range(0, 7)),
                    (j == n - 1) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
            end
            cyc(1'b0, 3'd0, 1'b1, 1'b0);
            repeat ($urandom_range(5, 50)) begin
                cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            end
        end

        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
